// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate cache with line refill and per-set round-robin replacement.
// Defining ASSOC_CACHE_STATS_EN adds the saturating hit_count/miss_count outputs.

module assoc_cache_chk #(
  parameter int WAYS = 2
) (
  input logic            clk,
  input logic            reset_n,
  input logic            mem_rd_req,
  input logic            mem_wr_en,
  input logic [WAYS-1:0] hit_vec
);

  a_one_mem_txn: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rd_req && mem_wr_en));

  a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(hit_vec));

endmodule

module assoc_cache #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int INDEX_BITS       = 2,
  parameter int WAY_BITS         = 1,
  parameter int BLOCK_BITS       = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [RAM_ADDRESS_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0]        req_wdata,
  output logic                        resp_valid,
  output logic [DATA_BITS-1:0]        resp_rdata,
  output logic                        mem_rd_req,
  output logic [RAM_ADDRESS_BITS-1:0] mem_addr,
  input  logic                        mem_rd_valid,
  input  logic [DATA_BITS-1:0]        mem_rd_data,
  output logic                        mem_wr_en,
  output logic [DATA_BITS-1:0]        mem_wr_data,
  input  logic                        mem_wr_ready
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAYS     = 1 << WAY_BITS;
  localparam int WORDS    = 1 << BLOCK_BITS;
  localparam int TAG_BITS = RAM_ADDRESS_BITS - INDEX_BITS - BLOCK_BITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_REFILL  = 3'd2,
    S_RESPOND = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [RAM_ADDRESS_BITS-1:0] r_addr;
  logic                        r_write;
  logic [DATA_BITS-1:0]        r_wdata;
  logic [BLOCK_BITS-1:0]       r_beat;
  logic [WAY_BITS-1:0]         r_victim;
  logic                        r_victim_full;

  logic [WAYS-1:0]             r_valid [SETS];
  logic [WAY_BITS-1:0]         r_rr    [SETS];
  logic [TAG_BITS-1:0]         r_tag   [SETS][WAYS];
  logic [DATA_BITS-1:0]        r_data  [SETS][WAYS][WORDS];

  logic [TAG_BITS-1:0]         w_tag;
  logic [INDEX_BITS-1:0]       w_index;
  logic [BLOCK_BITS-1:0]       w_offset;
  logic [WAYS-1:0]             w_hit_vec;
  logic [WAY_BITS-1:0]         w_hit_way;
  logic                        w_hit;
  logic [WAY_BITS-1:0]         w_free_way;
  logic                        w_all_valid;
  logic [WAY_BITS-1:0]         w_victim;
  logic                        w_last_beat;

  assign w_tag       = r_addr[RAM_ADDRESS_BITS-1 -: TAG_BITS];
  assign w_index     = r_addr[BLOCK_BITS +: INDEX_BITS];
  assign w_offset    = r_addr[BLOCK_BITS-1:0];
  assign w_hit       = |w_hit_vec;
  assign w_all_valid = &r_valid[w_index];
  assign w_victim    = w_all_valid ? r_rr[w_index] : w_free_way;
  assign w_last_beat = mem_rd_valid && (&r_beat);

  // Tag compare across the indexed set, plus lowest-numbered free way for allocation.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit_vec[w] = r_valid[w_index][w] && (r_tag[w_index][w] == w_tag);
      w_hit_way    = w_hit_vec[w] ? WAY_BITS'(w) : w_hit_way;
      w_free_way   = r_valid[w_index][w] ? w_free_way : WAY_BITS'(w);
    end
  end

  // Next-state and output decode; responses and memory strobes follow the current state.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    mem_rd_req   = 1'b0;
    mem_addr     = '0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = S_LOOKUP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (r_write) begin
          w_next_state = S_WRITE;
        end else if (w_hit) begin
          resp_valid   = 1'b1;
          resp_rdata   = r_data[w_index][w_hit_way][w_offset];
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_REFILL;
        end
      end
      S_REFILL: begin
        // The request drops as soon as the first beat has been captured.
        mem_rd_req = (r_beat == '0);
        mem_addr   = {w_tag, w_index, {BLOCK_BITS{1'b0}}};
        if (w_last_beat) begin
          w_next_state = S_RESPOND;
        end else begin
          w_next_state = S_REFILL;
        end
      end
      S_RESPOND: begin
        resp_valid   = 1'b1;
        resp_rdata   = r_data[w_index][r_victim][w_offset];
        w_next_state = S_IDLE;
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = r_addr;
        mem_wr_data = r_wdata;
        if (mem_wr_ready) begin
          resp_valid   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WRITE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, captured request, beat counter, valid bits and replacement pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_beat        <= '0;
      r_victim      <= '0;
      r_victim_full <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && req_valid) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_wdata;
      end
      if (r_state == S_LOOKUP) begin
        r_victim      <= w_victim;
        r_victim_full <= w_all_valid;
        r_beat        <= '0;
      end
      if ((r_state == S_REFILL) && mem_rd_valid) begin
        r_beat <= r_beat + BLOCK_BITS'(1);
        if (&r_beat) begin
          r_valid[w_index][r_victim] <= 1'b1;
          if (r_victim_full) begin
            r_rr[w_index] <= r_rr[w_index] + WAY_BITS'(1);
          end
        end
      end
    end
  end

  // Data and tag storage; only gated writes, contents survive reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOOKUP) && r_write && w_hit) begin
      r_data[w_index][w_hit_way][w_offset] <= r_wdata;
    end
    if ((r_state == S_REFILL) && mem_rd_valid) begin
      r_data[w_index][r_victim][r_beat] <= mem_rd_data;
      if (&r_beat) begin
        r_tag[w_index][r_victim] <= w_tag;
      end
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating lookup statistics, one increment per LOOKUP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) begin
        if (r_hit_count != 32'hFFFF_FFFF) begin
          r_hit_count <= r_hit_count + 32'd1;
        end
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) begin
          r_miss_count <= r_miss_count + 32'd1;
        end
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  assoc_cache_chk #(.WAYS(WAYS)) u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_rd_req (mem_rd_req),
    .mem_wr_en  (mem_wr_en),
    .hit_vec    (w_hit_vec)
  );

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: directed scenarios followed by random traffic,
// checked against a word-level memory image and a tag-level replacement model.

module tb_assoc_cache;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_rd_req;
  logic [9:0]  mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total;
  int bad;

  logic [31:0] gmem [1024];
  bit          m_valid [4][2];
  logic [5:0]  m_tag   [4][2];
  int          m_rr    [4];

  assoc_cache dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [9:0] a);
    bit h;
    h = 1'b0;
    for (int w = 0; w < 2; w++)
      if (m_valid[a[3:2]][w] && (m_tag[a[3:2]][w] == a[9:4])) h = 1'b1;
    return h;
  endfunction

  function automatic void model_fill(input logic [9:0] a);
    int s;
    int v;
    s = int'(a[3:2]);
    v = -1;
    for (int w = 1; w >= 0; w--)
      if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % 2;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[9:4];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  task automatic check_reset_outputs(input string where);
    chk({where, "_req_ready"},  32'(req_ready),  32'd1);
    chk({where, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({where, "_mem_rd_req"}, 32'(mem_rd_req), 32'd0);
    chk({where, "_mem_wr_en"},  32'(mem_wr_en),  32'd0);
    chk({where, "_resp_rdata"}, resp_rdata,      32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One CPU request with the bench acting as backing RAM. abort_at >= 0 pulls reset
  // once that many refill beats have been captured.
  task automatic xact(input logic wr, input logic [9:0] a, input logic [31:0] d,
                      input int stall, input bit exp_hit, input int abort_at);
    int beats, stall_cnt, lat;
    bit rd_seen, wr_seen, got, extra_done, was_hit;
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    beats = 0; stall_cnt = 0; lat = 0;
    rd_seen = 1'b0; wr_seen = 1'b0; got = 1'b0; extra_done = 1'b0;
    was_hit = model_hit(a);
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_wr_ready = 1'b0;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("resp_idle_low", 32'(resp_valid), 32'd0);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;
      mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
      if (rd_seen && (abort_at >= 0) && (beats == abort_at)) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (rd_seen && beats < 4) begin
        if ($urandom_range(0, 2) != 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = gmem[int'(base) + beats];
          beats++;
        end
      end else if (rd_seen && !extra_done) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = $urandom;
        extra_done   = 1'b1;
      end
      if (wr_seen) begin
        if (stall_cnt >= stall) mem_wr_ready = 1'b1;
        else stall_cnt++;
      end
      #1;
      chk("rd_wr_exclusive", 32'(mem_rd_req & mem_wr_en), 32'd0);
      if (mem_rd_req && !rd_seen) begin
        rd_seen = 1'b1;
        chk("refill_addr", 32'(mem_addr), 32'(base));
      end
      if (mem_wr_en && !wr_seen) begin
        wr_seen = 1'b1;
        chk("wr_addr", 32'(mem_addr), 32'(a));
        chk("wr_data", mem_wr_data, d);
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc;
      end
    end
    chk("resp_within_budget", 32'(got), 32'd1);
    if (got) begin
      if (wr) begin
        chk("wr_resp_in_ready_cycle", 32'(mem_wr_ready), 32'd1);
        chk("wr_no_refill", 32'(rd_seen), 32'd0);
        chk("wr_rdata_zero", resp_rdata, 32'd0);
        gmem[a] = d;
      end else begin
        chk("rd_data", resp_rdata, gmem[a]);
        chk("rd_hit", 32'(!rd_seen), 32'(exp_hit));
        chk("rd_no_write", 32'(wr_seen), 32'd0);
        if (exp_hit) chk("hit_latency", 32'(lat), 32'd1);
        if (!was_hit) model_fill(a);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 10'd0; req_wdata = 32'd0;
    mem_rd_valid = 1'b0; mem_rd_data = 32'd0; mem_wr_ready = 1'b0;
    for (int i = 0; i < 1024; i++) gmem[i] = $urandom;
    for (int i = 0; i < 4; i++) gmem[10'h040 + i] = 32'hA0 + 32'(i);
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Refill then hit in the same line.
    xact(1'b0, 10'h040, 32'd0, 0, 1'b0, -1);
    xact(1'b0, 10'h042, 32'd0, 0, 1'b1, -1);
`ifdef ASSOC_CACHE_STATS_EN
    chk("stats_miss", miss_count, 32'd1);
    chk("stats_hit", hit_count, 32'd1);
`endif

    // Write hit with stalled RAM, then read back.
    xact(1'b1, 10'h041, 32'hDEAD_BEEF, 3, 1'b1, -1);
    xact(1'b0, 10'h041, 32'd0, 0, 1'b1, -1);

    // Write miss does not allocate; the following read refills the written word.
    xact(1'b1, 10'h080, 32'h1234_5678, 1, 1'b0, -1);
    xact(1'b0, 10'h080, 32'd0, 0, 1'b0, -1);

    // Reset during a refill abandons the line and invalidates everything.
    xact(1'b0, 10'h0C4, 32'd0, 0, 1'b0, 3);
    xact(1'b0, 10'h0C4, 32'd0, 0, 1'b0, -1);
    xact(1'b0, 10'h042, 32'd0, 0, 1'b0, -1);

    // Replacement in set 0: way 0 is evicted first, way 1 survives.
    do_reset();
    xact(1'b0, 10'h000, 32'd0, 0, 1'b0, -1);
    xact(1'b0, 10'h010, 32'd0, 0, 1'b0, -1);
    xact(1'b0, 10'h020, 32'd0, 0, 1'b0, -1);
    xact(1'b0, 10'h010, 32'd0, 0, 1'b1, -1);
    xact(1'b0, 10'h000, 32'd0, 0, 1'b0, -1);

    // Random traffic over a small address window to force conflicts.
    for (int n = 0; n < 80; n++) begin
      logic [9:0] a;
      logic       wr;
      a  = 10'($urandom_range(0, 63));
      wr = ($urandom_range(0, 9) < 4);
      xact(wr, a, $urandom, $urandom_range(0, 2), model_hit(a), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
